// File: rtl/ns_arb_2to1_pkg.sv
// Shared field-size defaults and FSM state type for the 2-to-1 network-node arbiter.
package ns_arb_2to1_pkg;

    localparam int unsigned NS_ADDRESS_SIZE = 8;
    localparam int unsigned NS_DATA_SIZE    = 32;
    localparam int unsigned NS_REDUN_SIZE   = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RLS  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ns_arb_2to1_calc_redun.sv
// Redundancy code of a message: the {src,dst,dat} word folded by XOR into RSZ-bit
// chunks, with the top chunk zero-padded.
module calc_redun
    import ns_arb_2to1_pkg::*;
#(
    parameter int unsigned ASZ = NS_ADDRESS_SIZE,
    parameter int unsigned DSZ = NS_DATA_SIZE,
    parameter int unsigned RSZ = NS_REDUN_SIZE
) (
    input  logic [ASZ-1:0] src,
    input  logic [ASZ-1:0] dst,
    input  logic [DSZ-1:0] dat,
    output logic [RSZ-1:0] red
);

    localparam int unsigned MSZ = 2*ASZ + DSZ;
    localparam int unsigned NCH = (MSZ + RSZ - 1) / RSZ;

    logic [NCH*RSZ-1:0] padded;

    always_comb begin
        padded          = '0;
        padded[MSZ-1:0] = {src, dst, dat};
        red             = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            red = red ^ padded[k*RSZ +: RSZ];
        end
    end

endmodule

// File: rtl/ns_arb_2to1.sv
// Two-input round-robin message arbiter with one output register and optional
// redundancy-based drop of corrupted messages.
module ns_arb_2to1
    import ns_arb_2to1_pkg::*;
#(
    parameter int unsigned ASZ     = NS_ADDRESS_SIZE,
    parameter int unsigned DSZ     = NS_DATA_SIZE,
    parameter int unsigned RSZ     = NS_REDUN_SIZE,
    parameter bit          CHK_RED = 1'b1
) (
    input  logic           i_clk,
    input  logic           reset,

    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic [RSZ-1:0] i0_red,
    input  logic           i0_req,
    output logic           i0_ack,

    input  logic [ASZ-1:0] i1_src,
    input  logic [ASZ-1:0] i1_dst,
    input  logic [DSZ-1:0] i1_dat,
    input  logic [RSZ-1:0] i1_red,
    input  logic           i1_req,
    output logic           i1_ack,

    output logic [ASZ-1:0] o0_src,
    output logic [ASZ-1:0] o0_dst,
    output logic [DSZ-1:0] o0_dat,
    output logic [RSZ-1:0] o0_red,
    output logic           o0_req,
    input  logic           o0_ack,

    output logic           o_grant,
    output logic           o_drop_err,
    output logic [7:0]     o_drop_cnt
);

    arb_state_t     state, state_nxt;
    logic           elig0, elig1, sel, accept, red_ok;
    logic [ASZ-1:0] m_src, m_dst;
    logic [DSZ-1:0] m_dat;
    logic [RSZ-1:0] m_red, calc_red;

    calc_redun #(
        .ASZ(ASZ),
        .DSZ(DSZ),
        .RSZ(RSZ)
    ) u_calc_redun (
        .src(m_src),
        .dst(m_dst),
        .dat(m_dat),
        .red(calc_red)
    );

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round-robin: on a tie the input that did not win last time is served.
    always_comb begin
        elig0     = i0_req & ~i0_ack;
        elig1     = i1_req & ~i1_ack;
        sel       = (elig0 & elig1) ? ~o_grant : elig1;
        m_src     = sel ? i1_src : i0_src;
        m_dst     = sel ? i1_dst : i0_dst;
        m_dat     = sel ? i1_dat : i0_dat;
        m_red     = sel ? i1_red : i0_red;
        red_ok    = !CHK_RED || (m_red == calc_red);
        accept    = 1'b0;
        state_nxt = state;
        unique case (state)
            ARB_IDLE: begin
                if (!o0_ack && (elig0 || elig1)) begin
                    accept = 1'b1;
                    if (red_ok) begin
                        state_nxt = ARB_REQ;
                    end
                end
            end
            ARB_REQ: begin
                if (o0_ack) begin
                    state_nxt = ARB_RLS;
                end
            end
            ARB_RLS: begin
                if (!o0_ack) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    assign o0_req = (state == ARB_REQ);

    // Input acks release on their own, so a source can finish while the output is busy.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            o0_src     <= '0;
            o0_dst     <= '0;
            o0_dat     <= '0;
            o0_red     <= '0;
            i0_ack     <= 1'b0;
            i1_ack     <= 1'b0;
            o_grant    <= 1'b1;
            o_drop_err <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            if (i0_ack && !i0_req) begin
                i0_ack <= 1'b0;
            end
            if (i1_ack && !i1_req) begin
                i1_ack <= 1'b0;
            end
            if (accept) begin
                o_grant <= sel;
                if (sel) begin
                    i1_ack <= 1'b1;
                end else begin
                    i0_ack <= 1'b1;
                end
                if (red_ok) begin
                    o0_src <= m_src;
                    o0_dst <= m_dst;
                    o0_dat <= m_dat;
                    o0_red <= m_red;
                end else begin
                    o_drop_err <= 1'b1;
                    if (o_drop_cnt != '1) begin
                        o_drop_cnt <= o_drop_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule
